// File: rtl/control_despacho.sv
// Dispense/change sequencer: turns the vending FSM result into timed motor and coin pulses.
// Optional change sequencing (CHG/CGAP states, moneda_out) is built when DESPACHO_CAMBIO_EN is defined.
module control_despacho #(
    parameter int PULSE_CYCLES = 8,
    parameter int STOCK_INIT   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       listo,
    input  logic [1:0] producto,
    input  logic [1:0] cambio,
    input  logic       recarga,
    output logic [2:0] motor,
    output logic       moneda_out,
    output logic       ocupado,
    output logic       hecho,
    output logic [2:0] agotado,
    output logic       error,
    output logic       perdido
);

    typedef enum logic [2:0] {
        IDLE,
        VEND,
        VGAP,
`ifdef DESPACHO_CAMBIO_EN
        CHG,
        CGAP,
`endif
        DONE
    } state_t;

    localparam logic [7:0] P  = 8'(PULSE_CYCLES);
    localparam logic [3:0] S0 = 4'(STOCK_INIT);

    state_t          state;
    logic [7:0]      cnt;
    logic            listo_q;
    logic [1:0]      prod_r;
    logic [2:0][3:0] stock;
    logic            req;
    logic [1:0]      idx;

    assign req = listo & ~listo_q;
    assign idx = producto - 2'd1;

    always_comb begin
        for (int i = 0; i < 3; i++) agotado[i] = (stock[i] == 4'd0);
    end

`ifdef DESPACHO_CAMBIO_EN
    logic [1:0] chg_r;
`else
    logic unused_cambio;
    assign unused_cambio = ^cambio;
    assign moneda_out    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            listo_q <= 1'b1;  // a listo held high through reset is not an edge
            prod_r  <= '0;
            stock   <= {3{S0}};
            motor   <= '0;
            ocupado <= 1'b0;
            hecho   <= 1'b0;
            error   <= 1'b0;
            perdido <= 1'b0;
`ifdef DESPACHO_CAMBIO_EN
            moneda_out <= 1'b0;
            chg_r      <= '0;
`endif
        end else begin
            listo_q <= listo;
            hecho   <= 1'b0;
            error   <= 1'b0;
            if (req && state != IDLE) perdido <= 1'b1;
            case (state)
                IDLE: begin
                    if (req) begin
                        prod_r  <= producto;
                        ocupado <= 1'b1;
`ifdef DESPACHO_CAMBIO_EN
                        chg_r <= cambio;
`endif
                        if (producto != 2'd0 && stock[idx] != 4'd0) begin
                            stock[idx] <= stock[idx] - 4'd1;
                            cnt        <= P;
                            motor      <= 3'b001 << idx;
                            state      <= VEND;
                        end else begin
                            error <= (producto != 2'd0);
`ifdef DESPACHO_CAMBIO_EN
                            if (cambio != 2'd0) begin
                                state      <= CHG;
                                cnt        <= P;
                                moneda_out <= 1'b1;
                            end else
`endif
                            begin
                                state <= DONE;
                                hecho <= 1'b1;
                            end
                        end
                    end else if (recarga) begin
                        stock <= {3{S0}};
                    end
                end
                VEND: begin
                    if (cnt == 8'd1) begin
                        motor <= '0;
                        cnt   <= P;
                        state <= VGAP;
                    end else begin
                        motor <= 3'b001 << (prod_r - 2'd1);
                        cnt   <= cnt - 8'd1;
                    end
                end
                VGAP: begin
                    if (cnt == 8'd1) begin
`ifdef DESPACHO_CAMBIO_EN
                        if (chg_r != 2'd0) begin
                            state      <= CHG;
                            cnt        <= P;
                            moneda_out <= 1'b1;
                        end else
`endif
                        begin
                            state <= DONE;
                            hecho <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
`ifdef DESPACHO_CAMBIO_EN
                CHG: begin
                    if (cnt == 8'd1) begin
                        moneda_out <= 1'b0;
                        cnt        <= P;
                        state      <= CGAP;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                CGAP: begin
                    if (cnt == 8'd1) begin
                        chg_r <= chg_r - 2'd1;
                        if (chg_r != 2'd1) begin
                            cnt        <= P;
                            moneda_out <= 1'b1;
                            state      <= CHG;
                        end else begin
                            state <= DONE;
                            hecho <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
`endif
                DONE: begin
                    state   <= IDLE;
                    ocupado <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_control_despacho.sv
// Scoreboard bench for control_despacho: expected transaction outcomes are queued at request time
// and checked against the observed pulse train when hecho arrives.
module tb_control_despacho;

    localparam int P  = 4;
    localparam int SI = 2;
`ifdef DESPACHO_CAMBIO_EN
    localparam int CHG_EN = 1;
`else
    localparam int CHG_EN = 0;
`endif

    logic       clk = 1'b0;
    logic       rst, listo, recarga;
    logic [1:0] producto, cambio;
    logic [2:0] motor, agotado;
    logic       moneda_out, ocupado, hecho, error, perdido;

    typedef struct {
        int         lat;
        logic [2:0] mot;
        int         mcyc;
        int         mfirst;
        int         coins;
        int         errs;
    } exp_t;

    exp_t sb[$];
    int   stk[3];
    int   vectors = 0;
    int   errors  = 0;

    control_despacho #(.PULSE_CYCLES(P), .STOCK_INIT(SI)) dut (
        .clk(clk), .rst(rst), .listo(listo), .producto(producto), .cambio(cambio),
        .recarga(recarga), .motor(motor), .moneda_out(moneda_out), .ocupado(ocupado),
        .hecho(hecho), .agotado(agotado), .error(error), .perdido(perdido)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] model_agotado();
        logic [2:0] a;
        for (int i = 0; i < 3; i++) a[i] = (stk[i] == 0);
        return a;
    endfunction

    // One transaction: queue the expected outcome, raise listo, monitor until hecho, then compare.
    task automatic run_txn(input int p, input int c, input bit inject, input string tag);
        exp_t e, got;
        int v, k, n, hat, mc, mfirst, coins, coinh, errs, err_at;
        logic [2:0] mor;
        logic prev, busy1;
        v = (p != 0 && stk[p-1] > 0) ? 1 : 0;
        if (v == 1) stk[p-1]--;
        k = CHG_EN ? c : 0;
        e.lat    = 1 + 2*P*(v + k);
        e.mot    = (v == 1) ? 3'(1 << (p-1)) : 3'b000;
        e.mcyc   = (v == 1) ? P : 0;
        e.mfirst = (v == 1) ? 1 : 0;
        e.coins  = k;
        e.errs   = (p != 0 && v == 0) ? 1 : 0;
        sb.push_back(e);

        @(negedge clk); listo = 1'b0;
        @(negedge clk); listo = 1'b1; producto = 2'(p); cambio = 2'(c);
        n = 0; hat = 0; mc = 0; mfirst = 0; coins = 0; coinh = 0; errs = 0; err_at = 0;
        mor = 3'b000; prev = 1'b0; busy1 = 1'b0;
        while (hat == 0 && n < 200) begin
            @(negedge clk); n++;
            if (n == 1) busy1 = ocupado;
            if (motor != 3'b000) begin
                mc++;
                if (mfirst == 0) mfirst = n;
            end
            mor |= motor;
            if (moneda_out && !prev) coins++;
            if (moneda_out) coinh++;
            prev = moneda_out;
            if (error) begin errs++; err_at = n; end
            if (hecho) hat = n;
            if (inject && n == 1) listo = 1'b0;
            if (inject && n == 2) listo = 1'b1;
        end
        got = sb.pop_front();

        vectors++; if (hat !== got.lat) begin errors++; $display("FAIL %s hecho_lat: got %0d exp %0d", tag, hat, got.lat); end
        vectors++; if (busy1 !== 1'b1) begin errors++; $display("FAIL %s ocupado_t1: got %b exp 1", tag, busy1); end
        vectors++; if (mor !== got.mot) begin errors++; $display("FAIL %s motor: got %b exp %b", tag, mor, got.mot); end
        vectors++; if (mc !== got.mcyc || mfirst !== got.mfirst) begin
            errors++; $display("FAIL %s motor_cycles: got %0d from %0d exp %0d from %0d", tag, mc, mfirst, got.mcyc, got.mfirst);
        end
        vectors++; if (coins !== got.coins || coinh !== got.coins*P) begin
            errors++; $display("FAIL %s coins: got %0d pulses/%0d cycles exp %0d/%0d", tag, coins, coinh, got.coins, got.coins*P);
        end
        vectors++; if (errs !== got.errs || (errs == 1 && err_at !== 1)) begin
            errors++; $display("FAIL %s error: got %0d at %0d exp %0d at 1", tag, errs, err_at, got.errs);
        end
        @(negedge clk);
        vectors++; if (ocupado !== 1'b0 || hecho !== 1'b0) begin
            errors++; $display("FAIL %s idle_after: ocupado=%b hecho=%b exp 0 0", tag, ocupado, hecho);
        end
        vectors++; if (agotado !== model_agotado()) begin
            errors++; $display("FAIL %s agotado: got %b exp %b", tag, agotado, model_agotado());
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) stk[i] = SI;
    endtask

    task automatic test_reset();
        int busy;
        listo = 1'b1; producto = 2'd1; cambio = 2'd1; recarga = 1'b0;
        apply_reset();
        vectors++; if ({motor, moneda_out, ocupado, hecho, error, perdido} !== 8'b0) begin
            errors++; $display("FAIL reset_outputs: got %b exp 0", {motor, moneda_out, ocupado, hecho, error, perdido});
        end
        vectors++; if (agotado !== 3'b000) begin errors++; $display("FAIL reset_agotado: got %b exp 000", agotado); end
        busy = 0;
        repeat (6) begin @(negedge clk); if (ocupado) busy++; end
        vectors++; if (busy !== 0) begin errors++; $display("FAIL reset_listo_high: ocupado cycles %0d exp 0", busy); end
    endtask

    task automatic test_vend();
        run_txn(2, 0, 1'b0, "vend_p2");
    endtask

    task automatic test_change();
        run_txn(1, 3, 1'b0, "vend_p1_chg3");
        run_txn(0, 2, 1'b0, "no_prod_chg2");
        run_txn(0, 0, 1'b0, "no_prod_no_chg");
    endtask

    task automatic test_empty();
        run_txn(3, 0, 1'b0, "p3_first");
        run_txn(3, 0, 1'b0, "p3_second");
        run_txn(3, 1, 1'b0, "p3_empty");
        vectors++; if (agotado !== 3'b100) begin errors++; $display("FAIL empty_agotado: got %b exp 100", agotado); end
        @(negedge clk); listo = 1'b0; recarga = 1'b1;
        @(negedge clk); recarga = 1'b0;
        for (int i = 0; i < 3; i++) stk[i] = SI;
        vectors++; if (agotado !== 3'b000) begin errors++; $display("FAIL refill_agotado: got %b exp 000", agotado); end
    endtask

    task automatic test_lost();
        vectors++; if (perdido !== 1'b0) begin errors++; $display("FAIL lost_before: got %b exp 0", perdido); end
        run_txn(1, 1, 1'b1, "lost_edge");
        vectors++; if (perdido !== 1'b1) begin errors++; $display("FAIL lost_sticky: got %b exp 1", perdido); end
        run_txn(2, 0, 1'b0, "after_lost");
        vectors++; if (perdido !== 1'b1) begin errors++; $display("FAIL lost_still: got %b exp 1", perdido); end
    endtask

    task automatic test_rst_mid();
        int stop_n, busy;
        @(negedge clk); listo = 1'b0;
        @(negedge clk); listo = 1'b1; producto = 2'd3; cambio = 2'd2;
        stop_n = CHG_EN ? 2*P + 2 : 2;
        repeat (stop_n) @(negedge clk);
        vectors++; if (moneda_out !== 1'(CHG_EN) || ocupado !== 1'b1) begin
            errors++; $display("FAIL rst_mid_phase: moneda=%b ocupado=%b exp %0d 1", moneda_out, ocupado, CHG_EN);
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++; if ({motor, moneda_out, ocupado, hecho, error, perdido} !== 8'b0) begin
            errors++; $display("FAIL rst_mid_outputs: got %b exp 0", {motor, moneda_out, ocupado, hecho, error, perdido});
        end
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 3; i++) stk[i] = SI;
        busy = 0;
        repeat (5) begin @(negedge clk); if (ocupado) busy++; end
        vectors++; if (busy !== 0 || agotado !== 3'b000) begin
            errors++; $display("FAIL rst_mid_quiet: busy=%0d agotado=%b exp 0 000", busy, agotado);
        end
    endtask

    task automatic test_back_to_back();
        run_txn(3, 0, 1'b0, "b2b_p3_a");
        run_txn(3, 2, 1'b0, "b2b_p3_b");
        run_txn(3, 0, 1'b0, "b2b_p3_empty");
        run_txn(1, 2, 1'b0, "b2b_p1_chg2");
    endtask

    initial begin
        rst = 1'b1; listo = 1'b0; producto = 2'd0; cambio = 2'd0; recarga = 1'b0;
        test_reset();
        test_vend();
        test_change();
        test_empty();
        test_lost();
        test_rst_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/control_despacho.md
# control_despacho

Dispense/change sequencer that sits behind the vending FSM top level. It converts the FSM's `listo`/`producto`/`cambio` result into timed motor and coin-ejector pulses. It keeps a per-product stock count and exposes busy/done/empty status to the rest of the machine.

## Interface
- `PULSE_CYCLES`, default 8: high time and low gap, in clk cycles, of every motor or coin pulse (≥1, ≤255).
- `STOCK_INIT`, default 4: units per product loaded at reset or refill (1..15).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `listo`  in  1  FSM ready level; a 0→1 transition requests a transaction.
- `producto`  in  2  product code from FSM; 0 = none, 1..3 = product.
- `cambio`  in  2  change units to return (0..3).
- `recarga`  in  1  refill request level.
- `motor`  out  3  one-hot dispense motor; bit p-1 drives product p.
- `moneda_out`  out  1  coin-ejector pulse, one pulse per change unit.
- `ocupado`  out  1  transaction in progress.
- `hecho`  out  1  one-cycle pulse at end of transaction.
- `agotado`  out  3  bit p-1 high when stock of product p is 0.
- `error`  out  1  one-cycle pulse when the requested product is out of stock.
- `perdido`  out  1  sticky: a request edge arrived while `ocupado`.

## Operation
- Edge detect: `listo_q` register; request = `listo & ~listo_q`.
- States: IDLE, VEND, VGAP, CHG, CGAP, DONE. A single down-counter `cnt` times each pulse and gap.
- IDLE, request seen:
  - Capture `producto` into `prod_r` and `cambio` into `chg_r`.
  - If `prod_r`≠0 and its stock >0: decrement that stock, load `cnt`=PULSE_CYCLES, go to VEND.
  - If `prod_r`≠0 and its stock =0: pulse `error` and skip to the change phase.
  - If `prod_r`=0: skip to the change phase.
- Change phase entry: if `chg_r`≠0, go to CHG; otherwise go to DONE.
- VEND: `motor[prod_r-1]`=1. At `cnt`=1 go to VGAP with `cnt` reloaded. VGAP then goes to the change phase entry.
- CHG: `moneda_out`=1. At `cnt`=1 go to CGAP. At the end of CGAP, decrement `chg_r`; if the result is ≠0 go to CHG, otherwise go to DONE.
- DONE: `hecho`=1 for one cycle, then IDLE.
- `ocupado`=1 in every state except IDLE.
- Request edge while not IDLE: ignored and sets `perdido`. Only `rst` clears `perdido`.
- `recarga` high in IDLE with no request in the same cycle: all stocks set to STOCK_INIT. Ignored in any other state; a simultaneous request takes priority and the refill is dropped.
- Stock counters are 4-bit and saturate at 0; they never wrap. `agotado` is combinational from the stock==0 comparisons.

## Timing
- Reset values:
  - `motor`=0, `moneda_out`=0, `ocupado`=0, `hecho`=0, `error`=0, `perdido`=0, `agotado`=0.
  - All stocks = STOCK_INIT, state = IDLE.
  - `listo_q`=1, so a `listo` held high through reset is not treated as a request.
- For a request edge sampled at cycle t:
  - `ocupado` and the first state output (motor, moneda_out or hecho) are high from t+1.
  - `error` is high in cycle t+1 only.
- Motor high for cycles t+1..t+P, low for t+P+1..t+2P (P = PULSE_CYCLES).
- Each change unit adds 2P cycles: P high, P low.
- `hecho` is high at cycle t+1+2P·(v+k), where v=1 if the product was vended (else 0) and k=`cambio`. IDLE is reached the next cycle.
- A new request is accepted in the first IDLE cycle after DONE.
- `rst` mid-transaction: all outputs are 0 the next cycle and the stock reloads. There is no partial completion.

## Configuration
- `DESPACHO_CAMBIO_EN` defined: change sequencing as above; CHG/CGAP states are present.
- Not defined:
  - `cambio` is ignored, `moneda_out` is tied 0, and CHG/CGAP are not synthesized.
  - The change phase entry goes directly to DONE, so `hecho` arrives at t+1+2P·v.

## Test plan
With P=4, STOCK_INIT=2, macro defined unless stated:
- Reset then `listo` 0→1 with producto=2, cambio=0 → motor=3'b010 for 4 cycles, 4-cycle gap, `hecho` at t+9, stock2=1.
- producto=1, cambio=3 → 4 motor cycles, then three 4-high/4-low `moneda_out` pulses, `hecho` at t+33.
- Three transactions on product 3 → third gives `error` pulse at t+1, no motor, `agotado`=3'b100. Then `recarga` in IDLE → `agotado`=0.
- Second `listo` edge during VEND → ignored, `perdido`=1 until `rst`, `hecho` timing unchanged.
- `rst` asserted during CHG → next cycle all outputs 0 and stock=2. `listo` held high across reset gives no transaction.
- Macro undefined, producto=1, cambio=2 → `moneda_out` stays 0 and `hecho` at t+9.
